// File: rtl/ham_encode_tx.sv
// Hamming(7,4)x2 transmit encoder: one-byte input buffer, 14-bit codeword, MSB-first serializer paced by bit_tick.
// Optional macro HAM_ERR_INJECT_EN adds err_inject/err_pos to flip one transmitted bit for decoder testing.
module ham_encode_tx #(
  parameter int FRAME_GAP = 0,
  parameter int CW_W      = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      pcm_data,
  input  logic            pcm_valid,
  output logic            pcm_ready,
  input  logic            bit_tick,
`ifdef HAM_ERR_INJECT_EN
  input  logic            err_inject,
  input  logic [3:0]      err_pos,
`endif
  output logic [CW_W-1:0] ham_code,
  output logic            ser_bit,
  output logic            ser_valid,
  output logic            frame_start,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(FRAME_GAP - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [7:0]        r_buf;
  logic              r_bufFull;
  logic [CW_W-1:0]   r_shreg;
  logic [CW_W-1:0]   r_hamCode;
  logic [3:0]        r_bitCnt;
  logic [3:0]        r_gapCnt;
  logic              r_serBit;
  logic              r_serValid;
  logic              r_frameStart;
  logic              w_accept;
  logic              w_lastTick;
  logic              w_gapDone;
  logic [CW_W-1:0]   w_enc;
  logic [CW_W-1:0]   w_errMask;

  function automatic logic [6:0] encNibble(input logic [3:0] n);
    return {n, n[3] ^ n[2] ^ n[1], n[3] ^ n[2] ^ n[0], n[3] ^ n[1] ^ n[0]};
  endfunction

  assign w_enc      = {encNibble(r_buf[7:4]), encNibble(r_buf[3:0])};
  assign w_accept   = pcm_valid && !r_bufFull;
  assign w_lastTick = bit_tick && (r_bitCnt == 4'd13);
  assign w_gapDone  = bit_tick && (r_gapCnt == GAP_LAST);

`ifdef HAM_ERR_INJECT_EN
  // The flip only affects the shift register; ham_code keeps the clean word.
  assign w_errMask = (err_inject && (err_pos <= 4'd13)) ?
                     ({{(CW_W-1){1'b0}}, 1'b1} << err_pos) : '0;
`else
  assign w_errMask = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (r_bufFull) w_nextState = S_LOAD;
      S_LOAD:  w_nextState = S_SHIFT;
      S_SHIFT: begin
        if (w_lastTick) begin
          if (FRAME_GAP > 0)  w_nextState = S_GAP;
          else if (r_bufFull) w_nextState = S_LOAD;
          else                w_nextState = S_IDLE;
        end
      end
      S_GAP:   if (w_gapDone) w_nextState = r_bufFull ? S_LOAD : S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf        <= '0;
      r_bufFull    <= 1'b0;
      r_shreg      <= '0;
      r_hamCode    <= '0;
      r_bitCnt     <= '0;
      r_gapCnt     <= '0;
      r_serBit     <= 1'b0;
      r_serValid   <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_serValid   <= 1'b0;
      r_frameStart <= 1'b0;
      if (w_accept) begin
        r_buf     <= pcm_data;
        r_bufFull <= 1'b1;
      end else if (r_state == S_LOAD) begin
        r_bufFull <= 1'b0;
      end
      case (r_state)
        S_LOAD: begin
          r_shreg   <= w_enc ^ w_errMask;
          r_hamCode <= w_enc;
          r_bitCnt  <= '0;
        end
        S_SHIFT: begin
          if (bit_tick) begin
            r_serBit     <= r_shreg[CW_W-1];
            r_shreg      <= r_shreg << 1;
            r_serValid   <= 1'b1;
            r_frameStart <= (r_bitCnt == 4'd0);
            r_bitCnt     <= r_bitCnt + 4'd1;
          end
        end
        S_GAP: begin
          r_serBit <= 1'b0;
          if (bit_tick) r_gapCnt <= w_gapDone ? 4'd0 : r_gapCnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign pcm_ready   = !r_bufFull;
  assign busy        = (r_state != S_IDLE) || r_bufFull;
  assign ham_code    = r_hamCode;
  assign ser_bit     = r_serBit;
  assign ser_valid   = r_serValid;
  assign frame_start = r_frameStart;

endmodule

// File: tb/tb_ham_encode_tx.sv
// Bench for ham_encode_tx: a byte-level scoreboard checks every serial bit, plus directed latency/gap/reset cases.
module tb_ham_encode_tx;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pcm_data;
  logic        pcm_valid;
  logic        bit_tick;
  logic        pcm_ready;
  logic [13:0] ham_code;
  logic        ser_bit, ser_valid, frame_start, busy;

  logic        gValid, gReady, gSerBit, gSerValid, gFrameStart, gBusy;
  logic [13:0] gHam;

  int          checks = 0;
  int          passes = 0;
  bit          tickEn = 1'b1;
  int          tickPeriod = 8;
  int          tickPhase = 0;

  logic [7:0]  expQ[$];
  logic [13:0] hamLog[$];
  logic [13:0] curCw = '0;
  logic [13:0] rxWord = '0;
  int          bitIdx = 0;
  logic        prevReady = 1'b0;
  logic        prevRst = 1'b0;
  int          svCnt = 0, tickCnt = 0, firstTick = 0, lastTick = 0;
  int          gSv = 0, gTick14 = 0, gTick15 = 0;

  ham_encode_tx #(.FRAME_GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .pcm_data(pcm_data), .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready), .bit_tick(bit_tick), .ham_code(ham_code),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .frame_start(frame_start), .busy(busy)
  );

  ham_encode_tx #(.FRAME_GAP(3)) dutGap (
    .clk(clk), .rst_n(rst_n), .pcm_data(pcm_data), .pcm_valid(gValid),
    .pcm_ready(gReady), .bit_tick(bit_tick), .ham_code(gHam),
    .ser_bit(gSerBit), .ser_valid(gSerValid), .frame_start(gFrameStart), .busy(gBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Codeword straight from the parity equations: each nibble n gives {n, p(n&1110), p(n&1101), p(n&1011)}.
  function automatic logic [13:0] encModel(input logic [7:0] b);
    logic [3:0]  n;
    logic [13:0] cw;
    cw = '0;
    for (int h = 0; h < 2; h++) begin
      n  = (h == 0) ? b[7:4] : b[3:0];
      cw = (cw << 7) | 14'({n, ^(n & 4'b1110), ^(n & 4'b1101), ^(n & 4'b1011)});
    end
    return cw;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Offer one byte to the selected instance and wait for the handshake; optionally keep valid high afterwards.
  task automatic applyStimulus(input logic [7:0] b, input bit toGap, input bit hold);
    logic r;
    int   k;
    pcm_data = b;
    if (toGap) gValid = 1'b1; else pcm_valid = 1'b1;
    k = 0;
    r = 1'b0;
    while (!r && k < 400) begin
      r = toGap ? gReady : pcm_ready;
      nextCycle();
      k++;
    end
    checkOutput("acceptTimeout", r, 1);
    checkOutput("readyDropAfterAccept", toGap ? gReady : pcm_ready, 0);
    if (!hold) begin
      if (toGap) gValid = 1'b0; else pcm_valid = 1'b0;
    end
  endtask

  task automatic waitSv(input int n, input int budget);
    int k;
    k = 0;
    while (svCnt < n && k < budget) begin
      nextCycle();
      k++;
    end
    checkOutput("serValidTimeout", svCnt >= n, 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (tickEn) begin
        tickPhase = (tickPhase + 1) % tickPeriod;
        bit_tick  = (tickPhase == 0);
      end else begin
        tickPhase = 0;
        bit_tick  = 1'b0;
      end
    end
  end

  // Scoreboard: handshakes fill the expected-byte queue, every ser_valid is checked against the model.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      expQ.delete();
      bitIdx = 0;
    end else begin
      if (prevRst && prevReady && pcm_valid) expQ.push_back(pcm_data);
      if (bit_tick) tickCnt++;
      if (ser_valid) begin
        checkOutput("validNeedsTick", bit_tick, 1);
        if (bitIdx == 0) begin
          if (expQ.size() == 0) checkOutput("frameWithoutByte", expQ.size(), 1);
          else curCw = encModel(expQ.pop_front());
          checkOutput("hamCode", ham_code, curCw);
          hamLog.push_back(ham_code);
        end
        checkOutput("frameStart", frame_start, bitIdx == 0);
        checkOutput("serBit", ser_bit, curCw[13 - bitIdx]);
        rxWord = {rxWord[12:0], ser_bit};
        if (svCnt == 0) firstTick = tickCnt;
        lastTick = tickCnt;
        svCnt++;
        bitIdx = (bitIdx + 1) % 14;
      end else begin
        checkOutput("frameStartIdle", frame_start, 0);
      end
      if (gSerValid) begin
        gSv++;
        if (gSv == 14) gTick14 = tickCnt;
        if (gSv == 15) gTick15 = tickCnt;
      end else if (bit_tick && gSv == 14) begin
        checkOutput("gapSerBitZero", gSerBit, 0);
      end
    end
    prevReady = pcm_ready;
    prevRst   = rst_n;
  end

  initial begin
    rst_n     = 1'b0;
    pcm_data  = 8'h00;
    pcm_valid = 1'b0;
    gValid    = 1'b0;
    bit_tick  = 1'b0;
    repeat (3) nextCycle();
    checkOutput("resetHam", ham_code, 0);
    checkOutput("resetSerBit", ser_bit, 0);
    checkOutput("resetSerValid", ser_valid, 0);
    checkOutput("resetBusy", busy, 0);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("readyAfterReset", pcm_ready, 1);

    // Single byte 0xA5: latency of ham_code and full serial word.
    svCnt = 0;
    pcm_data  = 8'hA5;
    pcm_valid = 1'b1;
    nextCycle();
    pcm_valid = 1'b0;
    checkOutput("readyFull", pcm_ready, 0);
    checkOutput("busyFull", busy, 1);
    nextCycle();
    checkOutput("latencyEarly", ham_code, 0);
    nextCycle();
    checkOutput("latencyHam", ham_code, 14'h292D);
    waitSv(14, 400);
    checkOutput("serialWordA5", rxWord, 14'h292D);
    repeat (3) nextCycle();
    checkOutput("serBitHold", ser_bit, 1);
    checkOutput("idleNotBusy", busy, 0);

    // Three bytes with valid held high: no idle tick between frames.
    svCnt = 0;
    hamLog.delete();
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b0, 1'b1);
    applyStimulus(8'h3C, 1'b0, 1'b0);
    waitSv(42, 2000);
    checkOutput("contiguousTicks", lastTick - firstTick + 1, 42);
    checkOutput("ham00", hamLog.size() > 0 ? hamLog[0] : 14'h1, 14'h0000);
    checkOutput("hamFF", hamLog.size() > 1 ? hamLog[1] : 14'h0, 14'h3FFF);
    checkOutput("ham3C", hamLog.size() > 2 ? hamLog[2] : 14'h0, 14'h0F61);
    checkOutput("serialWord3C", rxWord, 14'h0F61);

    // FRAME_GAP=3 instance: exactly three silent ticks between its two frames.
    gSv = 0;
    applyStimulus(8'h81, 1'b1, 1'b1);
    applyStimulus(8'h7E, 1'b1, 1'b0);
    for (int k = 0; k < 1500 && gSv < 28; k++) nextCycle();
    checkOutput("gapFramesDone", gSv, 28);
    checkOutput("gapTicks", gTick15 - gTick14, 4);
    checkOutput("gapHam", gHam, encModel(8'h7E));

    // Stalled baud strobe: nothing is sent, block stays busy, then resumes.
    tickEn = 1'b0;
    repeat (4) nextCycle();
    svCnt = 0;
    applyStimulus(8'h96, 1'b0, 1'b0);
    repeat (100) nextCycle();
    checkOutput("noTickNoValid", svCnt, 0);
    checkOutput("stallBusy", busy, 1);
    applyStimulus(8'h69, 1'b0, 1'b0);
    checkOutput("stallReady", pcm_ready, 0);
    tickEn = 1'b1;
    waitSv(1, 2 * tickPeriod + 4);
    waitSv(28, 600);

    // Reset in the middle of frame 0x5A, then a clean 0x12 frame.
    repeat (20) nextCycle();
    svCnt = 0;
    applyStimulus(8'h5A, 1'b0, 1'b0);
    waitSv(6, 400);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetHam", ham_code, 0);
    checkOutput("midResetSerBit", ser_bit, 0);
    checkOutput("midResetSerValid", ser_valid, 0);
    checkOutput("midResetFrameStart", frame_start, 0);
    checkOutput("midResetBusy", busy, 0);
    checkOutput("midResetReady", pcm_ready, 1);
    repeat (2) nextCycle();
    rst_n = 1'b1;
    repeat (30) nextCycle();
    checkOutput("noResend", svCnt, 6);
    svCnt = 0;
    applyStimulus(8'h12, 1'b0, 1'b0);
    waitSv(14, 400);
    checkOutput("serialWord12", rxWord, 14'h0595);
    repeat (4) nextCycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
